// File: rtl/instr_fetch_unit.sv
// Instruction fetch: at most DEPTH words requested or buffered, in-order, one-cycle buffer latency (no bypass).
// Backpressure: a full buffer stops requests; redirect flushes and drops stale responses; a zero word halts fetch.
module instr_fetch_unit #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] instr_pc_plus4,
  output logic              halted
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_nxt;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     count;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [31:0]       buf_dat [DEPTH];
  logic [ADDR_W-1:0] buf_pc  [DEPTH];
  logic [ADDR_W-1:0] resp_pc;
  logic              halted_q;

  logic [CW:0] inflight;
  logic        fire;
  logic        pop;
  logic        halt_now;
  logic        redir;
  logic        flush;
  logic        stale;
  logic        push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Responses come back in order, so the address of each one is tracked by a shadow PC.
  always_comb begin
    inflight        = {1'b0, outstanding} + {1'b0, count};
    imem_req        = rst_n && !halted_q && (inflight < (CW+1)'(DEPTH));
    imem_addr       = fetch_pc;
    fire            = imem_req && imem_gnt;
    instr_valid     = (count != '0);
    instr           = buf_dat[rd_ptr];
    instr_pc        = buf_pc[rd_ptr];
    instr_pc_plus4  = instr_pc + ADDR_W'(4);
    halted          = halted_q;
    pop             = instr_valid && instr_ready;
    halt_now        = pop && (instr == 32'h0);
    redir           = redirect && !halted_q;
    flush           = redir || halt_now;
    stale           = (drop_cnt != '0);
    push            = imem_rvalid && !stale && !halted_q && !flush;
    outstanding_nxt = outstanding + CW'(fire) - CW'(imem_rvalid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= '0;
      resp_pc     <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      halted_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_dat[i] <= '0;
        buf_pc[i]  <= '0;
      end
    end else begin
      outstanding <= outstanding_nxt;
      if (halt_now) halted_q <= 1'b1;

      if (redir) fetch_pc <= redirect_pc;
      else if (fire) fetch_pc <= fetch_pc + ADDR_W'(4);

      // Everything still in flight after this edge, including a same-cycle grant, is stale.
      if (redir) drop_cnt <= outstanding_nxt;
      else if (imem_rvalid && stale) drop_cnt <= drop_cnt - CW'(1);

      // The first non-stale response after a redirect belongs to redirect_pc.
      if (redir) resp_pc <= redirect_pc;
      else if (imem_rvalid && !stale) resp_pc <= resp_pc + ADDR_W'(4);

      if (push) begin
        buf_dat[wr_ptr] <= imem_rdata;
        buf_pc[wr_ptr]  <= resp_pc;
      end

      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= count + CW'(push) - CW'(pop);
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model plus a scoreboard of hand-computed expected instructions.
module tb_instr_fetch_unit;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [31:0]   instr;
  logic [AW-1:0] instr_pc;
  logic [AW-1:0] instr_pc_plus4;
  logic          halted;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [AW-1:0] pc4;
    logic [31:0]   word;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] pend[$];
  int            budget = 0;
  int            grant_cnt = 0;
  bit            resp_en = 1'b1;
  bit            zero_en = 1'b0;
  bit            halt_pending = 1'b0;
  int            n_pass = 0;
  int            n_total = 0;

  instr_fetch_unit #(.ADDR_W(AW), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    if (zero_en && a == 6'h08) return 32'h0;
    return 32'h1000_0000 | {26'h0, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Memory: decisions made on the falling edge take effect at the next rising edge.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (!rst_n) pend.delete();
    if (rst_n && resp_en && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend.pop_front());
    end
    imem_gnt = rst_n && (budget > 0);
    if (imem_req && imem_gnt) begin
      pend.push_back(imem_addr);
      budget--;
      grant_cnt++;
    end
  end

  // Monitor: every consumed instruction is compared with the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (halt_pending) begin
        check("halt_next_cycle", {31'h0, halted}, 32'h1);
        halt_pending = 1'b0;
      end
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_instr: got pc %h word %h, required no instruction", instr_pc, instr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("instr_pc", {26'h0, instr_pc}, {26'h0, e.pc});
          check("instr_pc_plus4", {26'h0, instr_pc_plus4}, {26'h0, e.pc4});
          check("instr", instr, e.word);
          if (e.word == 32'h0) halt_pending = 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_word(input logic [AW-1:0] pc, input logic [AW-1:0] pc4, input logic [31:0] w);
    exp_t e;
    e.pc = pc; e.pc4 = pc4; e.word = w;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) tick();
    check(name, exp_q.size(), 0);
  endtask

  task automatic do_redirect(input logic [AW-1:0] pc);
    redirect = 1'b1;
    redirect_pc = pc;
    tick();
    redirect = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"}, {31'h0, imem_req}, 32'h0);
    check({tag, "_imem_addr"}, {26'h0, imem_addr}, 32'h0);
    check({tag, "_instr_valid"}, {31'h0, instr_valid}, 32'h0);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_instr_pc"}, {26'h0, instr_pc}, 32'h0);
    check({tag, "_instr_pc_plus4"}, {26'h0, instr_pc_plus4}, 32'h4);
    check({tag, "_halted"}, {31'h0, halted}, 32'h0);
  endtask

  initial begin
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("first_req", {31'h0, imem_req}, 32'h1);
    check("first_addr", {26'h0, imem_addr}, 32'h0);

    // Sequential fetch
    instr_ready = 1'b1;
    expect_word(6'h00, 6'h04, 32'h1000_0000);
    expect_word(6'h04, 6'h08, 32'h1000_0004);
    expect_word(6'h08, 6'h0C, 32'h1000_0008);
    budget = 3;
    drain("seq_drain", 40);

    // Address wrap
    do_redirect(6'h38);
    expect_word(6'h38, 6'h3C, 32'h1000_0038);
    expect_word(6'h3C, 6'h00, 32'h1000_003C);
    expect_word(6'h00, 6'h04, 32'h1000_0000);
    budget = 3;
    drain("wrap_drain", 40);
    check("wrap_fetch_pc", {26'h0, imem_addr}, 32'h04);

    // Backpressure
    instr_ready = 1'b0;
    do_redirect(6'h10);
    grant_cnt = 0;
    budget = 5;
    tick(4);
    for (int i = 0; i < 8; i++) begin
      check("bp_valid", {31'h0, instr_valid}, 32'h1);
      check("bp_pc", {26'h0, instr_pc}, 32'h10);
      check("bp_instr", instr, 32'h1000_0010);
      tick();
    end
    check("bp_grants", grant_cnt, 2);
    expect_word(6'h10, 6'h14, 32'h1000_0010);
    expect_word(6'h14, 6'h18, 32'h1000_0014);
    expect_word(6'h18, 6'h1C, 32'h1000_0018);
    expect_word(6'h1C, 6'h20, 32'h1000_001C);
    expect_word(6'h20, 6'h24, 32'h1000_0020);
    instr_ready = 1'b1;
    drain("bp_drain", 60);

    // Redirect with two requests in flight
    resp_en = 1'b0;
    grant_cnt = 0;
    budget = 2;
    tick(5);
    check("inflight_grants", grant_cnt, 2);
    do_redirect(6'h20);
    expect_word(6'h20, 6'h24, 32'h1000_0020);
    expect_word(6'h24, 6'h28, 32'h1000_0024);
    resp_en = 1'b1;
    budget = 2;
    drain("redirect_drain", 40);

    // Halt on a zero word at 0x08
    zero_en = 1'b1;
    do_redirect(6'h00);
    expect_word(6'h00, 6'h04, 32'h1000_0000);
    expect_word(6'h04, 6'h08, 32'h1000_0004);
    expect_word(6'h08, 6'h0C, 32'h0000_0000);
    budget = 4;
    drain("halt_drain", 40);
    tick();
    check("halted", {31'h0, halted}, 32'h1);
    budget = 2;
    do_redirect(6'h30);
    for (int i = 0; i < 8; i++) begin
      check("halt_no_req", {31'h0, imem_req}, 32'h0);
      check("halt_no_valid", {31'h0, instr_valid}, 32'h0);
      tick();
    end
    check("halt_sticky", {31'h0, halted}, 32'h1);
    budget = 0;

    // Reset clears halt, then reset again with a full buffer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    zero_en = 1'b0;
    #1;
    check("halt_cleared", {31'h0, halted}, 32'h0);
    instr_ready = 1'b0;
    budget = 2;
    tick(6);
    check("full_valid", {31'h0, instr_valid}, 32'h1);
    check("full_pc", {26'h0, instr_pc}, 32'h0);
    budget = 0;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_reset_req", {31'h0, imem_req}, 32'h1);
    check("post_reset_addr", {26'h0, imem_addr}, 32'h0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, width of PC and instruction-memory byte address.
REQ-002 SHALL have parameter DEPTH, default 2, instruction-buffer entries and the maximum number of requests in flight plus buffered.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_req  output  1  fetch request valid.
REQ-006 SHALL have port imem_addr  output  ADDR_W  byte address of the requested instruction.
REQ-007 SHALL have port imem_gnt  input  1  memory accepts the request this cycle.
REQ-008 SHALL have port imem_rvalid  input  1  read data valid; responses return in request order, at least 1 cycle after grant.
REQ-009 SHALL have port imem_rdata  input  32  instruction word.
REQ-010 SHALL have port redirect  input  1  taken branch; restart fetch at redirect_pc.
REQ-011 SHALL have port redirect_pc  input  ADDR_W  branch target address.
REQ-012 SHALL have port instr_valid  output  1  buffer head holds a valid instruction.
REQ-013 SHALL have port instr_ready  input  1  decode consumes the head this cycle.
REQ-014 SHALL have port instr  output  32  head instruction word.
REQ-015 SHALL have port instr_pc  output  ADDR_W  address of the head instruction.
REQ-016 SHALL have port instr_pc_plus4  output  ADDR_W  instr_pc+4, modulo 2^ADDR_W.
REQ-017 SHALL have port halted  output  1  sticky; an all-zero instruction was consumed.

Function
REQ-018 SHALL assert imem_req when not halted and (outstanding + buffer occupancy) < DEPTH; imem_addr SHALL equal the fetch PC.
REQ-019 SHALL hold imem_req and imem_addr stable until imem_gnt; a grant SHALL increment the fetch PC by 4, wrapping modulo 2^ADDR_W, and increment outstanding.
REQ-020 SHALL decrement outstanding on each imem_rvalid; a simultaneous grant and rvalid SHALL leave outstanding unchanged.
REQ-021 SHALL write a non-stale response (word plus its address) into the buffer tail on imem_rvalid; it SHALL appear at instr* no earlier than the next cycle (no bypass).
REQ-022 SHALL drive instr_valid = buffer non-empty; instr, instr_pc and instr_pc_plus4 SHALL come from the head entry and SHALL remain stable while instr_valid=1 and instr_ready=0.
REQ-023 SHALL pop the head when instr_valid and instr_ready are both 1; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-024 SHALL never overflow the buffer; REQ-018 guarantees a slot for every outstanding response.
REQ-025 On redirect=1, SHALL empty the buffer, load the fetch PC with redirect_pc, and mark every outstanding request, including one granted that same cycle, as stale.
REQ-026 SHALL discard stale responses without writing the buffer, counted with a drop counter of width clog2(DEPTH+1); stale responses SHALL still decrement outstanding.
REQ-027 SHALL request from redirect_pc no earlier than the cycle after redirect; the cycle-level order is redirect → fetch PC loaded → imem_req with the new address.
REQ-028 On redirect and pop in the same cycle, the pop SHALL count as consumed, and the flush SHALL win for all other entries.
REQ-029 On popping an instruction equal to 32'h0, SHALL set halted, empty the buffer, deassert imem_req from the next cycle, and discard all later responses.
REQ-030 While halted, SHALL ignore redirect; only rst_n SHALL clear halted.

Reset
REQ-031 While rst_n=0, SHALL drive imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0, instr_pc_plus4=4, and halted=0.
REQ-032 Reset SHALL set the fetch PC to 0, clear outstanding, the drop counter and the buffer, and take effect immediately regardless of clk, including mid-transaction.
REQ-033 SHALL raise imem_req with address 0 in the first cycle after rst_n deasserts.

Verification
REQ-034 Sequential fetch: zero-latency-plus-1 memory with gnt=1, ready=1; words at addresses 0, 4, 8 → instr_pc 0, 4, 8 in order, instr_pc_plus4 4, 8, 12.
REQ-035 Backpressure: ready=0 for 10 cycles → at most 2 requests granted, instr_valid held 1, instr/instr_pc stable; after release → no lost or duplicated words.
REQ-036 Redirect with 2 in flight: redirect_pc=0x20 → both stale responses dropped; next instr_pc=0x20, then 0x24.
REQ-037 Wrap: ADDR_W=6, fetch from 0x3C → next request addr 0x00, and instr_pc_plus4 at 0x3C = 0x00.
REQ-038 Halt: consume 32'h0 at pc 0x08 → halted=1 next cycle, imem_req=0 thereafter, redirect ignored, late response never reaches instr_valid.
REQ-039 Reset mid-operation: assert rst_n=0 with 2 outstanding and buffer full → all outputs at reset values asynchronously; after release → request address 0.
